// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - merges CPU fetch and data SRAM-like ports onto one downstream port
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   inst_req/addr -> inst_addr_ok   fetch address phase (read-only, word size)
//   inst_data_ok, inst_rdata        fetch response
//   data_req/wr/wstrb/addr/size/wdata -> data_addr_ok   data address phase
//   data_data_ok, data_rdata        data response
//   m_req/wr/wstrb/addr/size/wdata  downstream address phase, m_addr_ok accepts
//   m_data_ok, m_rdata              downstream in-order response
//   err                             sticky: response seen with nothing outstanding
module mem_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic        err
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Lock state: a presented-but-not-accepted request pins the owner.
    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lk_state_t;

    lk_state_t lk_state_q, lk_state_d;

    logic [DEPTH-1:0] fifo_q;      // owner per outstanding transaction, 1 = data
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             err_q;

    logic lk_v;
    logic lk_o;
    logic sel;                     // 1 = data port owns the downstream port
    logic full;
    logic empty;
    logic acc;
    logic push;
    logic pop;
    logic head;

    assign lk_v  = (lk_state_q != LK_IDLE);
    assign lk_o  = (lk_state_q == LK_DATA);
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lk_state_q <= LK_IDLE;
        end else begin
            lk_state_q <= lk_state_d;
        end
    end

    // Next-state: a full FIFO keeps m_req low, so the lock simply holds.
    always_comb begin
        lk_state_d = lk_state_q;
        if (acc) begin
            lk_state_d = LK_IDLE;
        end else if (m_req) begin
            lk_state_d = sel ? LK_DATA : LK_INST;
        end
    end

    // Outputs: selection and downstream address phase
    always_comb begin
        sel          = 1'b0;
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_wstrb      = 4'b0;
        m_addr       = inst_addr;
        m_size       = 3'd2;
        m_wdata      = 32'd0;
        acc          = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;

        if (lk_v) begin
            sel = lk_o;
        end else if (data_req) begin
            sel = 1'b1;
        end

        if (sel) begin
            m_wr    = data_wr;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_size  = data_size;
            m_wdata = data_wdata;
        end

        // Full gating uses the registered count only, so m_data_ok never
        // reaches m_req combinationally.
        m_req        = resetn && !full && (sel ? data_req : inst_req);
        acc          = m_req && m_addr_ok;
        inst_addr_ok = acc && !sel;
        data_addr_ok = acc && sel;
    end

    // Response routing
    assign push         = acc;
    assign pop          = resetn && m_data_ok && !empty;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign err          = err_q;

    // Owner FIFO, pointers, count, sticky error
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (m_data_ok && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic        err;

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];   // expected owner of each accepted transaction, 1 = data

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_size(m_size), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .err(err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one downstream response this cycle and compare it against the
    // scoreboard head; with nothing expected, no requester may see data_ok.
    task automatic respond_chk(input logic [31:0] rdata, input string tag);
        bit owner;
        m_data_ok = 1'b1;
        m_rdata   = rdata;
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_inst_dok"}, 64'(inst_data_ok), 64'd0);
            check_eq({tag, "_data_dok"}, 64'(data_data_ok), 64'd0);
        end else begin
            owner = exp_q.pop_front();
            check_eq({tag, "_inst_dok"}, 64'(inst_data_ok), 64'(!owner));
            check_eq({tag, "_data_dok"}, 64'(data_data_ok), 64'(owner));
            check_eq({tag, "_rdata"}, 64'(owner ? data_rdata : inst_rdata), 64'(rdata));
        end
    endtask

    task automatic respond(input logic [31:0] rdata, input string tag);
        respond_chk(rdata, tag);
        tick();
        m_data_ok = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'hBFC0_0000;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_size  = 3'd2;
        data_wdata = 32'h0;
        m_rdata    = 32'h0;
        m_addr_ok  = 1'b1;
        m_data_ok  = 1'b1;

        // Reset: outputs forced low even with live requests and responses
        tick();
        tick();
        #1;
        check_eq("rst_m_req", 64'(m_req), 64'd0);
        check_eq("rst_inst_aok", 64'(inst_addr_ok), 64'd0);
        check_eq("rst_data_dok", 64'(data_data_ok), 64'd0);
        check_eq("rst_inst_dok", 64'(inst_data_ok), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        inst_req  = 1'b0;
        m_data_ok = 1'b0;
        m_addr_ok = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Simultaneous requests: data wins, inst follows
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        data_req  = 1'b1;
        data_addr = 32'h8000_1000;
        m_addr_ok = 1'b1;
        #1;
        check_eq("sim_m_addr0", 64'(m_addr), 64'h8000_1000);
        check_eq("sim_data_aok", 64'(data_addr_ok), 64'd1);
        check_eq("sim_inst_aok0", 64'(inst_addr_ok), 64'd0);
        if (data_addr_ok) exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0;
        #1;
        check_eq("sim_m_addr1", 64'(m_addr), 64'hBFC0_0000);
        check_eq("sim_m_size1", 64'(m_size), 64'd2);
        check_eq("sim_inst_aok1", 64'(inst_addr_ok), 64'd1);
        exp_q.push_back(1'b0);
        tick();
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        respond(32'hAAAA_0001, "sim_rspA");
        respond(32'hBBBB_0002, "sim_rspB");

        // Lock: inst stalled 3 cycles, data rises meanwhile
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_req  = 1'b1;
                data_addr = 32'h8000_2000;
            end
            #1;
            check_eq("lk_m_req", 64'(m_req), 64'd1);
            check_eq("lk_m_addr", 64'(m_addr), 64'hBFC0_0000);
            check_eq("lk_data_aok", 64'(data_addr_ok), 64'd0);
            tick();
        end
        m_addr_ok = 1'b1;
        #1;
        check_eq("lk_inst_aok", 64'(inst_addr_ok), 64'd1);
        check_eq("lk_m_addr_acc", 64'(m_addr), 64'hBFC0_0000);
        exp_q.push_back(1'b0);
        tick();
        inst_req = 1'b0;
        #1;
        check_eq("lk_data_aok2", 64'(data_addr_ok), 64'd1);
        check_eq("lk_m_addr2", 64'(m_addr), 64'h8000_2000);
        exp_q.push_back(1'b1);
        tick();
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        respond(32'h1111_0001, "lk_rsp0");
        respond(32'h1111_0002, "lk_rsp1");

        // Full: four fetches accepted, fifth waits for a response
        inst_req  = 1'b1;
        m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'hBFC0_0000 + 32'(i * 4);
            #1;
            check_eq("full_fill_aok", 64'(inst_addr_ok), 64'd1);
            exp_q.push_back(1'b0);
            tick();
        end
        inst_addr = 32'hBFC0_0010;
        #1;
        check_eq("full_m_req", 64'(m_req), 64'd0);
        check_eq("full_inst_aok", 64'(inst_addr_ok), 64'd0);
        tick();
        respond_chk(32'h2222_0000, "full_pop");
        check_eq("full_popcyc_m_req", 64'(m_req), 64'd0);
        tick();
        m_data_ok = 1'b0;
        #1;
        check_eq("full_fifth_aok", 64'(inst_addr_ok), 64'd1);
        exp_q.push_back(1'b0);
        tick();
        inst_req  = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h8000_4000;
        #1;
        check_eq("full_again_m_req", 64'(m_req), 64'd0);
        check_eq("full_again_daok", 64'(data_addr_ok), 64'd0);
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) respond(32'h2222_0001 + 32'(i), "full_drain");

        // Same-cycle push and pop at cnt=2, covering pointer wrap
        m_addr_ok = 1'b1;
        data_req  = 1'b1;
        data_addr = 32'h8000_5000;
        #1;
        check_eq("pp_pre0", 64'(data_addr_ok), 64'd1);
        exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0;
        inst_req = 1'b1;
        #1;
        check_eq("pp_pre1", 64'(inst_addr_ok), 64'd1);
        exp_q.push_back(1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            data_req = (i % 3) != 0;
            inst_req = (i % 3) == 0;
            respond_chk(32'h3333_0000 + 32'(i), "pp_rsp");
            check_eq("pp_aok", 64'({inst_addr_ok, data_addr_ok}), 64'(((i % 3) != 0) ? 2'b01 : 2'b10));
            exp_q.push_back((i % 3) != 0);
            tick();
        end
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_data_ok = 1'b0;
        m_addr_ok = 1'b0;
        respond(32'h3333_1000, "pp_drain0");
        respond(32'h3333_1001, "pp_drain1");

        // Write passthrough
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_wdata = 32'h1234_ABCD;
        data_size  = 3'd1;
        data_addr  = 32'h8000_3000;
        m_addr_ok  = 1'b1;
        #1;
        check_eq("wr_m_wr", 64'(m_wr), 64'd1);
        check_eq("wr_m_wstrb", 64'(m_wstrb), 64'h3);
        check_eq("wr_m_wdata", 64'(m_wdata), 64'h1234_ABCD);
        check_eq("wr_m_size", 64'(m_size), 64'd1);
        check_eq("wr_m_addr", 64'(m_addr), 64'h8000_3000);
        check_eq("wr_data_aok", 64'(data_addr_ok), 64'd1);
        exp_q.push_back(1'b1);
        tick();
        data_req  = 1'b0;
        data_wr   = 1'b0;
        m_addr_ok = 1'b0;
        respond(32'h0, "wr_rsp");
        #1;
        check_eq("wr_err", 64'(err), 64'd0);

        // Spurious response with nothing outstanding
        respond(32'hDEAD_BEEF, "spur");
        #1;
        check_eq("spur_err", 64'(err), 64'd1);
        tick();
        #1;
        check_eq("spur_err_hold", 64'(err), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check_eq("spur_err_clr", 64'(err), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Merges the CPU's instruction-fetch and data-access SRAM-like ports onto a single downstream SRAM-like port for a unified memory or bridge interface. It arbitrates address-phase requests with data priority. Once a request is presented it stays locked until accepted. The owner of every accepted transaction is recorded in an in-order FIFO so each `data_ok`/`rdata` response returns to the correct requester. It sits between `mips_cpu` and the memory-side bridge.

## Interface
- `DEPTH`, default 4: maximum outstanding accepted transactions. Must be a power of two, 2..16.
- `PTR_W`, default 2: log2(DEPTH).
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `inst_req`  in  1  fetch request.
- `inst_addr`  in  32  fetch address.
- `inst_rdata`  out  32  fetch read data.
- `inst_addr_ok`  out  1  fetch address accepted.
- `inst_data_ok`  out  1  fetch data valid.
- `data_req`  in  1  data request.
- `data_wr`  in  1  data write (1) or read (0).
- `data_wstrb`  in  4  byte strobes.
- `data_addr`  in  32  data address.
- `data_size`  in  3  access size.
- `data_wdata`  in  32  write data.
- `data_rdata`  out  32  data read data.
- `data_addr_ok`  out  1  data address accepted.
- `data_data_ok`  out  1  data response.
- `m_req`, `m_wr`, `m_wstrb[3:0]`, `m_addr[31:0]`, `m_size[2:0]`, `m_wdata[31:0]`  out: downstream request.
- `m_rdata`  in  32  downstream read data.
- `m_addr_ok`  in  1  downstream address accepted.
- `m_data_ok`  in  1  downstream response.
- `err`  out  1  sticky protocol error: `m_data_ok` arrived with no outstanding transaction.

## Operation
- State: owner FIFO (DEPTH x 1 bit, 0=inst, 1=data), write and read pointers, count `cnt[PTR_W:0]`, lock flag `lk_v`, lock owner `lk_o`, `err`.
- `full = (cnt == DEPTH)`.
- Select:
  - If `lk_v`, sel = `lk_o`.
  - Else if `data_req`, sel = data.
  - Else if `inst_req`, sel = inst.
- Downstream request:
  - `m_req = !full && (sel==data ? data_req : inst_req)`.
  - With sel=inst: `m_wr=0`, `m_wstrb=0`, `m_size=3'd2`, `m_wdata=0`, `m_addr=inst_addr`.
  - With sel=data: all `m_*` fields are driven from the `data_*` inputs.
- Accept: `acc = m_req && m_addr_ok`.
  - `inst_addr_ok = acc && sel==inst`; `data_addr_ok = acc && sel==data`.
  - On `acc`, push sel into the FIFO.
- Lock:
  - If `m_req && !m_addr_ok`, set `lk_v=1`, `lk_o=sel`.
  - On `acc`, clear `lk_v`.
  - While locked, the other requester is not selected, even if it has higher priority.
- Response:
  - On `m_data_ok` with `cnt!=0`, pop the FIFO head.
  - `inst_data_ok = m_data_ok && cnt!=0 && head==0`; `data_data_ok = m_data_ok && cnt!=0 && head==1`.
  - `inst_rdata = data_rdata = m_rdata`.
  - `m_data_ok` with `cnt==0`: no pop, no `*_data_ok`, set `err=1` until reset.
- Count:
  - Push and pop in the same cycle: `cnt` unchanged, both pointers advance.
  - Push only: `cnt+1`. Pop only: `cnt-1`.
  - Pointers wrap modulo DEPTH.
- Full: `m_req` is forced to 0 and the requesters see no `addr_ok`. A lock, if set, is held. A pop in the full cycle does not enable a push in that same cycle; this avoids a combinational path from `m_data_ok` to `m_req`.

## Timing
- Address phase is combinational: `m_req`, the `m_*` fields and `*_addr_ok` are valid in the same cycle as the inputs. Arbitration adds no latency.
- Response routing is combinational from `m_data_ok` and the registered FIFO head.
- Responses complete in acceptance order. Downstream must also return responses in order.
- Reset values:
  - `cnt=0`, both pointers 0, `lk_v=0`, `err=0`.
  - While `resetn=0`, `m_req`, `*_addr_ok` and `*_data_ok` are forced to 0.
- Reset mid-operation: the FIFO is discarded. Downstream responses for pre-reset transactions then hit `cnt==0` and set `err`. The system must also reset the downstream side.
- A requester dropping `req` while locked violates the protocol. The arbiter then deasserts `m_req` and keeps the lock until acceptance.

## Test plan
- Simultaneous requests: `inst_req=1` (0xBFC00000) and `data_req=1` (read 0x80001000), `m_addr_ok=1`. Data is granted first with `m_addr=0x80001000`; inst is granted the next cycle. Responses A then B give `data_data_ok` then `inst_data_ok`.
- Lock: inst presented, `m_addr_ok=0` for 3 cycles, `data_req` rises in cycle 2. `m_addr` stays 0xBFC00000 until accept; data is granted the cycle after.
- Full: DEPTH=4, four inst fetches accepted, no responses. A fifth request sees `m_req=0`. The cycle after one `m_data_ok`, the fifth is accepted and `cnt` returns to 4.
- Same-cycle push and pop at `cnt=2`: `cnt` stays 2 and the correct owner receives `data_ok`. Repeat for 10 cycles to cover pointer wrap.
- Spurious response: `m_data_ok=1` with `cnt=0`. No `*_data_ok`, `err=1` and it holds; `resetn=0` for 1 cycle clears it.
- Write: `data_wr=1`, `wstrb=4'b0011`, `wdata=0x1234ABCD`, `size=1`. All fields appear unchanged on `m_*`, and `data_data_ok` is routed correctly.
